md5_nonce_scheduler: RTL and testbench
======================================

# md5_nonce_scheduler

Sequencer that drives the 64-step MD5 pipeline (`md5_top`) for the 2015 day 4 search: given a secret key, it emits padded 512-bit blocks for key‖decimal(N), N = START_NONCE, START_NONCE+1, …, and checks each returned digest for a leading run of zero hex digits. It sits between the key loader and `md5_top`, and reports the lowest matching N. It relies on the pipeline returning digests in issue order, one per accepted block, so no nonce tag travels with the data.

## Interface
- `MAX_KEY_BYTES`, 16: maximum key length in bytes; MAX_KEY_BYTES+MAX_DIGITS ≤ 55.
- `MAX_DIGITS`, 8: maximum decimal digits of N.
- `ZERO_NIBBLES`, 5: number of leading zero hex digits required, 1..8.
- `START_NONCE`, 1: first N issued, ≥1.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `key_ready`  out  1  high only in IDLE.
- `key_valid`  in  1  key handshake.
- `key_data`  in  8*MAX_KEY_BYTES  key bytes; byte 0 at the MSB end.
- `key_len`  in  $clog2(MAX_KEY_BYTES+1)  key length in bytes; values above MAX_KEY_BYTES are clamped.
- `md5_block_ready`  in  1  from pipeline.
- `md5_block_valid`  out  1  block offered.
- `md5_block_data`  out  512  message byte 0 at [511:504].
- `digest_valid`  in  1  from pipeline.
- `digest_data`  in  128  {d,c,b,a}.
- `result_valid`  out  1  search finished; held until reset.
- `result_found`  out  1  1 = match, 0 = N space exhausted.
- `result_nonce`  out  32  binary N of the first match.
- `busy`  out  1  high in ISSUE or DRAIN.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Every output resets to 0, with `key_ready`=1 (IDLE).
- IDLE: on `key_valid`&&`key_ready`, latch the key and the clamped length. Load the BCD counter with START_NONCE, the binary issue nonce with START_NONCE, and issued_cnt = returned_cnt = 0. Go to ISSUE.
- Block build is combinational from registers only:
  - message = key bytes, then the BCD digits most-significant first with no leading zeros (ASCII 0x30+d), then 0x80, then zeros.
  - Bytes 56..63 hold the bit length L = 8*(key_len+ndigits) as a little-endian 64-bit value: byte 56 = L[7:0], byte 57 = L[15:8], rest 0.
- ISSUE: `md5_block_valid`=1. On handshake:
  - Increment issued_cnt.
  - BCD-increment the counter with carry ripple; ndigits grows when the carry leaves the top digit.
  - If the increment would need MAX_DIGITS+1 digits, go to DRAIN instead of issuing more.
- Valid and data are stable while `md5_block_ready`=0.
- Digest check:
  - Only a digest with issued_cnt≠returned_cnt is counted. Others (stale, after reset) are discarded in any state.
  - Hex digit j (0-based) is taken from byte m=j/2 of a, i.e. `digest_data`[8m+7:8m]. Even j uses the high nibble, odd j the low nibble.
  - Match = hex digits 0..ZERO_NIBBLES-1 all zero.
- On a counted digest, check the nonce START_NONCE+returned_cnt, then increment returned_cnt.
  - First match (ISSUE or DRAIN): latch the nonce into `result_nonce`, set `result_found`=1, go to DONE, and deassert `md5_block_valid` the next cycle.
  - A handshake in the same cycle as the match still counts; its digest is later ignored.
- DRAIN: `md5_block_valid`=0. When returned_cnt==issued_cnt with no match, go to DONE with `result_found`=0 and `result_nonce`=0.
- DONE: `result_valid`=1. All inputs are ignored until `reset`.
- Counters are 32 bits; issued_cnt−returned_cnt never exceeds the pipeline depth (≤66 when paired with `md5_top`).

## Timing
- Key handshake at edge k: `busy`=1 and `md5_block_valid`=1 from cycle k+1.
- Next block data is valid in the cycle after each handshake. There are no bubbles beyond what `md5_block_ready` imposes.
- Match digest at edge t: `result_valid`, `result_found` and `result_nonce` are registered and visible at t+1; `busy` falls at t+1.
- Exhaustion: DONE one cycle after the edge on which the last outstanding digest is counted.
- `reset` asserted at any time forces IDLE asynchronously and discards all progress; in-flight digests are later discarded by the outstanding check.

## Test plan
- Key "abc", START_NONCE=1, `md5_block_ready` held 1 → first block bytes 0..4 = 61 62 63 31 80, byte 56 = 0x20, all other bytes 0. Second block byte 3 = 0x32.
- Key "abcdef", ZERO_NIBBLES=5, with `md5_top` attached → `result_valid` with `result_found`=1 and `result_nonce`=609043. Key "pqrstuv" → 1048970.
- Transition 9→10 and 99→100: ndigits increments, L grows by 8, 0x80 moves one byte later.
- MAX_DIGITS=2, ZERO_NIBBLES=8, dummy pipeline returning nonzero digests → exactly 99 blocks issued (N 1..99), then `result_found`=0 after the 99th digest.
- `md5_block_ready` held low 10 cycles mid-run → `md5_block_valid` and `md5_block_data` unchanged throughout; the nonce sequence has no gaps or duplicates.
- `reset` pulsed with 30 digests in flight, new key loaded → stale digests ignored; results match a clean run.

Source files
------------

// File: rtl/md5_nonce_scheduler_if.sv
// Handshake bundle tying the nonce scheduler to its key loader, the MD5 pipeline and the result consumer.
// The master side is the scheduler; the slave side is everything around it.
interface md5_nonce_scheduler_if #(
    parameter int MAX_KEY_BYTES = 16
) ();
    localparam int KEY_LEN_W = $clog2(MAX_KEY_BYTES + 1);

    logic                       key_ready;
    logic                       key_valid;
    logic [8*MAX_KEY_BYTES-1:0] key_data;
    logic [KEY_LEN_W-1:0]       key_len;

    logic                       md5_block_ready;
    logic                       md5_block_valid;
    logic [511:0]               md5_block_data;

    logic                       digest_valid;
    logic [127:0]               digest_data;

    logic                       result_valid;
    logic                       result_found;
    logic [31:0]                result_nonce;
    logic                       busy;

    modport master (
        output key_ready,
        input  key_valid, key_data, key_len,
        input  md5_block_ready,
        output md5_block_valid, md5_block_data,
        input  digest_valid, digest_data,
        output result_valid, result_found, result_nonce, busy
    );

    modport slave (
        input  key_ready,
        output key_valid, key_data, key_len,
        output md5_block_ready,
        input  md5_block_valid, md5_block_data,
        output digest_valid, digest_data,
        input  result_valid, result_found, result_nonce, busy
    );
endinterface

// File: rtl/md5_nonce_scheduler.sv
// Feeds padded key||decimal(N) blocks to the MD5 pipeline and reports the lowest N whose digest
// starts with ZERO_NIBBLES zero hex digits. Digests are assumed to return in issue order.
module md5_nonce_scheduler #(
    parameter int MAX_KEY_BYTES = 16,
    parameter int MAX_DIGITS    = 8,
    parameter int ZERO_NIBBLES  = 5,
    parameter int START_NONCE   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    md5_nonce_scheduler_if.master bus
);
    localparam int KEY_LEN_W = $clog2(MAX_KEY_BYTES + 1);
    localparam int NDIG_W    = $clog2(MAX_DIGITS + 1);
    localparam int BCD_W     = 4 * MAX_DIGITS;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    function automatic logic [BCD_W-1:0] to_bcd(input int value);
        logic [BCD_W-1:0] bcd;
        int v;
        bcd = '0;
        v   = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return bcd;
    endfunction

    function automatic int count_digits(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (v > 0) begin
                n = n + 1;
                v = v / 10;
            end
        end
        return n;
    endfunction

    localparam logic [BCD_W-1:0]  START_BCD  = to_bcd(START_NONCE);
    localparam logic [NDIG_W-1:0] START_NDIG = NDIG_W'(count_digits(START_NONCE));

    state_t                     state_q, state_d;
    logic [8*MAX_KEY_BYTES-1:0] key_q, key_d;
    logic [KEY_LEN_W-1:0]       key_len_q, key_len_d;
    logic [BCD_W-1:0]           bcd_q, bcd_d;
    logic [NDIG_W-1:0]          ndig_q, ndig_d;
    logic [31:0]                issued_q, issued_d;
    logic [31:0]                returned_q, returned_d;
    logic [31:0]                nonce_q, nonce_d;
    logic                       found_q, found_d;
    logic                       key_ready_q, key_ready_d;
    logic                       block_valid_q, block_valid_d;
    logic                       busy_q, busy_d;
    logic                       result_valid_q, result_valid_d;

    logic [511:0]               block;
    int                         msg_len;
    logic [15:0]                bit_len;
    logic [BCD_W-1:0]           bcd_inc;
    logic                       bcd_carry;
    logic                       ndig_grow;
    logic                       digest_zero;
    logic                       handshake;
    logic                       counted;

    // Block is built purely from registers so it stays stable while the pipeline stalls.
    always_comb begin
        block   = '0;
        msg_len = int'(key_len_q) + int'(ndig_q);
        for (int k = 0; k < MAX_KEY_BYTES; k++) begin
            if (k < int'(key_len_q)) begin
                block[511 - 8*k -: 8] = key_q[8*(MAX_KEY_BYTES-1-k) +: 8];
            end
        end
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < int'(ndig_q)) begin
                block[511 - 8*(int'(key_len_q) + i) -: 8] =
                    {4'h3, bcd_q[4*(int'(ndig_q) - 1 - i) +: 4]};
            end
        end
        block[511 - 8*msg_len -: 8] = 8'h80;
        bit_len                     = 16'(8 * msg_len);
        block[511 - 8*56 -: 8]      = bit_len[7:0];
        block[511 - 8*57 -: 8]      = bit_len[15:8];
    end

    // A carry out of the last digit means N no longer fits in MAX_DIGITS.
    always_comb begin
        bcd_inc   = bcd_q;
        bcd_carry = 1'b1;
        ndig_grow = 1'b0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (bcd_carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    bcd_carry         = 1'b0;
                end
            end
        end
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i == int'(ndig_q) && bcd_inc[4*i +: 4] != 4'd0) begin
                ndig_grow = 1'b1;
            end
        end
    end

    // Hex digit j lives in byte j/2 of word a, high nibble first.
    always_comb begin
        digest_zero = 1'b1;
        for (int j = 0; j < ZERO_NIBBLES; j++) begin
            if (j % 2 == 0) begin
                if (bus.digest_data[8*(j/2) + 4 +: 4] != 4'h0) digest_zero = 1'b0;
            end else begin
                if (bus.digest_data[8*(j/2) +: 4] != 4'h0) digest_zero = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        key_len_d  = key_len_q;
        bcd_d      = bcd_q;
        ndig_d     = ndig_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        nonce_d    = nonce_q;
        found_d    = found_q;

        handshake = block_valid_q && bus.md5_block_ready;
        counted   = bus.digest_valid && (issued_q != returned_q)
                    && (state_q == ISSUE || state_q == DRAIN);

        case (state_q)
            IDLE: begin
                if (bus.key_valid && key_ready_q) begin
                    key_d      = bus.key_data;
                    key_len_d  = (bus.key_len > KEY_LEN_W'(MAX_KEY_BYTES))
                                 ? KEY_LEN_W'(MAX_KEY_BYTES) : bus.key_len;
                    bcd_d      = START_BCD;
                    ndig_d     = START_NDIG;
                    issued_d   = '0;
                    returned_d = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    issued_d = issued_q + 32'd1;
                    if (bcd_carry) begin
                        state_d = DRAIN;
                    end else begin
                        bcd_d  = bcd_inc;
                        ndig_d = ndig_q + NDIG_W'(ndig_grow);
                    end
                end
            end
            DRAIN: begin
                if (issued_q == returned_q) begin
                    state_d = DONE;
                    found_d = 1'b0;
                    nonce_d = '0;
                end
            end
            default: begin
            end
        endcase

        // A match overrides any transition chosen above, including one into DRAIN.
        if (counted) begin
            returned_d = returned_q + 32'd1;
            if (digest_zero) begin
                found_d = 1'b1;
                nonce_d = 32'(START_NONCE) + returned_q;
                state_d = DONE;
            end
        end

        key_ready_d    = (state_d == IDLE);
        block_valid_d  = (state_d == ISSUE);
        busy_d         = (state_d == ISSUE) || (state_d == DRAIN);
        result_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            key_q          <= '0;
            key_len_q      <= '0;
            bcd_q          <= '0;
            ndig_q         <= '0;
            issued_q       <= '0;
            returned_q     <= '0;
            nonce_q        <= '0;
            found_q        <= 1'b0;
            key_ready_q    <= 1'b1;
            block_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            key_len_q      <= key_len_d;
            bcd_q          <= bcd_d;
            ndig_q         <= ndig_d;
            issued_q       <= issued_d;
            returned_q     <= returned_d;
            nonce_q        <= nonce_d;
            found_q        <= found_d;
            key_ready_q    <= key_ready_d;
            block_valid_q  <= block_valid_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.key_ready       = key_ready_q;
    assign bus.md5_block_valid = block_valid_q;
    assign bus.md5_block_data  = block;
    assign bus.busy            = busy_q;
    assign bus.result_valid    = result_valid_q;
    assign bus.result_found    = found_q;
    assign bus.result_nonce    = nonce_q;
endmodule

// File: tb/tb_md5_nonce_scheduler.sv
// Directed bench for md5_nonce_scheduler with a fixed-latency in-order stand-in for the MD5 pipeline.
// Digests are chosen per nonce so that matches, near-misses and stale returns land where intended.
module tb_md5_nonce_scheduler;
    localparam int MKB = 16;
    localparam int MD  = 3;
    localparam int ZN  = 5;
    localparam int SN  = 1;
    localparam int KLW = $clog2(MKB + 1);

    localparam logic [511:0] BLK_ABC1 =
        {8'h61, 8'h62, 8'h63, 8'h31, 8'h80, {51{8'h00}}, 8'h20, {7{8'h00}}};
    localparam logic [511:0] BLK_ABC10 =
        {8'h61, 8'h62, 8'h63, 8'h31, 8'h30, 8'h80, {50{8'h00}}, 8'h28, {7{8'h00}}};
    localparam logic [511:0] BLK_ABC100 =
        {8'h61, 8'h62, 8'h63, 8'h31, 8'h30, 8'h30, 8'h80, {49{8'h00}}, 8'h30, {7{8'h00}}};

    logic clk = 1'b0;
    logic reset;

    int    checkCount = 0;
    int    passCount  = 0;
    int    failCount  = 0;
    int    cycle      = 0;
    string modelKey   = "";
    int    expNonce   = SN;
    int    issuedBlocks = 0;
    int    pipeLat    = 40;
    int    targetNonce = -1;
    int    nearNonce   = -1;
    int    lowNonce    = -1;
    int    exhaustLast = -1;
    int    matchCycle  = -1;
    int    drainLast   = -1;
    int    pendN[$];
    int    pendT[$];
    bit    pendStale[$];

    always #5 clk = ~clk;

    md5_nonce_scheduler_if #(.MAX_KEY_BYTES(MKB)) bus ();

    md5_nonce_scheduler #(
        .MAX_KEY_BYTES(MKB),
        .MAX_DIGITS   (MD),
        .ZERO_NIBBLES (ZN),
        .START_NONCE  (SN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    function automatic logic [511:0] modelBlock(input string key, input int n);
        string        msg;
        logic [511:0] blk;
        int           bits;
        msg  = {key, $sformatf("%0d", n)};
        blk  = '0;
        for (int i = 0; i < msg.len(); i++) blk[511 - 8*i -: 8] = msg[i];
        blk[511 - 8*msg.len() -: 8] = 8'h80;
        bits = 8 * msg.len();
        blk[511 - 8*56 -: 8] = bits[7:0];
        blk[511 - 8*57 -: 8] = bits[15:8];
        return blk;
    endfunction

    function automatic logic [127:0] digestFor(input int n, input bit stale);
        if (stale)            return '0;
        if (n == targetNonce) return {32'h0BADF00D, 32'hCAFEBABE, 32'h12345678, 32'hFF0A0000};
        if (n == nearNonce)   return {32'h0BADF00D, 32'hCAFEBABE, 32'h12345678, 32'h00100000};
        if (n == lowNonce)    return {32'h0BADF00D, 32'hCAFEBABE, 32'h12345678, 32'h00000001};
        return {32'(n), 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h87654321};
    endfunction

    // Pipeline stand-in: records every accepted block, returns its digest pipeLat cycles later.
    always @(negedge clk) begin
        int n;
        bit stale;
        cycle++;
        if (matchCycle >= 0 && cycle == matchCycle + 1) begin
            checkOutput("match result_valid", bus.result_valid, 1'b1);
            checkOutput("match result_found", bus.result_found, 1'b1);
            checkOutput("match result_nonce", bus.result_nonce, 32'(targetNonce));
            checkOutput("match busy low", bus.busy, 1'b0);
            checkOutput("match block_valid low", bus.md5_block_valid, 1'b0);
        end
        if (drainLast >= 0 && cycle == drainLast + 1) begin
            checkOutput("drain result_valid still low", bus.result_valid, 1'b0);
            checkOutput("drain busy", bus.busy, 1'b1);
            checkOutput("drain block_valid low", bus.md5_block_valid, 1'b0);
        end
        if (drainLast >= 0 && cycle == drainLast + 2) begin
            checkOutput("exhaust result_valid", bus.result_valid, 1'b1);
            checkOutput("exhaust result_found", bus.result_found, 1'b0);
            checkOutput("exhaust busy low", bus.busy, 1'b0);
        end
        if (bus.md5_block_valid === 1'b1 && bus.md5_block_ready === 1'b1) begin
            checkOutput($sformatf("block N=%0d", expNonce), bus.md5_block_data,
                        modelBlock(modelKey, expNonce));
            if (modelKey == "abc") begin
                if (expNonce == 1)   checkOutput("abc N=1 block", bus.md5_block_data, BLK_ABC1);
                if (expNonce == 2)   checkOutput("abc N=2 byte3", bus.md5_block_data[487:480], 8'h32);
                if (expNonce == 10)  checkOutput("abc N=10 block", bus.md5_block_data, BLK_ABC10);
                if (expNonce == 100) checkOutput("abc N=100 block", bus.md5_block_data, BLK_ABC100);
            end
            pendN.push_back(expNonce);
            pendT.push_back(cycle);
            pendStale.push_back(1'b0);
            expNonce++;
            issuedBlocks++;
        end
        bus.digest_valid = 1'b0;
        if (pendN.size() > 0 && cycle - pendT[0] >= pipeLat) begin
            n     = pendN.pop_front();
            void'(pendT.pop_front());
            stale = pendStale.pop_front();
            bus.digest_data  = digestFor(n, stale);
            bus.digest_valid = 1'b1;
            if (!stale && n == targetNonce) begin
                matchCycle = cycle;
                checkOutput("result_valid before match", bus.result_valid, 1'b0);
            end
            if (!stale && n == exhaustLast) drainLast = cycle;
        end
    end

    task automatic applyStimulus(input string key, input int lenPort);
        modelKey     = key;
        expNonce     = SN;
        issuedBlocks = 0;
        @(posedge clk); #1;
        checkOutput({"key_ready before load ", key}, bus.key_ready, 1'b1);
        bus.key_data = '0;
        for (int i = 0; i < key.len() && i < MKB; i++) bus.key_data[8*(MKB-1-i) +: 8] = key[i];
        bus.key_len   = KLW'(lenPort);
        bus.key_valid = 1'b1;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        checkOutput({"busy after key ", key}, bus.busy, 1'b1);
        checkOutput({"block_valid after key ", key}, bus.md5_block_valid, 1'b1);
        checkOutput({"key_ready after key ", key}, bus.key_ready, 1'b0);
    endtask

    task automatic waitResult(input int limit, input string tag);
        int i;
        i = 0;
        while (bus.result_valid !== 1'b1 && i < limit) begin
            @(posedge clk); #1;
            i++;
        end
        checkOutput({tag, " result_valid"}, bus.result_valid, 1'b1);
    endtask

    task automatic resetDut();
        @(posedge clk); #1;
        reset = 1'b1;
        foreach (pendStale[i]) pendStale[i] = 1'b1;
        matchCycle  = -1;
        drainLast   = -1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 500 && pendN.size() > 0; i++) @(posedge clk);
        #1;
        checkOutput("stale digests drained", pendN.size() == 0, 1'b1);
    endtask

    initial begin
        reset                = 1'b1;
        bus.key_valid        = 1'b0;
        bus.key_data         = '0;
        bus.key_len          = '0;
        bus.md5_block_ready  = 1'b0;
        bus.digest_valid     = 1'b0;
        bus.digest_data      = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset key_ready", bus.key_ready, 1'b1);
        checkOutput("reset block_valid", bus.md5_block_valid, 1'b0);
        checkOutput("reset busy", bus.busy, 1'b0);
        checkOutput("reset result_valid", bus.result_valid, 1'b0);
        checkOutput("reset result_found", bus.result_found, 1'b0);
        checkOutput("reset result_nonce", bus.result_nonce, 32'd0);
        reset = 1'b0;

        // Key "abc": digit-count transitions, a ready stall, near-misses, then a match at 105.
        pipeLat     = 40;
        targetNonce = 105;
        nearNonce   = 50;
        lowNonce    = 7;
        bus.md5_block_ready = 1'b1;
        applyStimulus("abc", 3);
        for (int i = 0; i < 200 && issuedBlocks < 30; i++) begin
            @(posedge clk); #1;
        end
        bus.md5_block_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("stall %0d block_valid", i), bus.md5_block_valid, 1'b1);
            checkOutput($sformatf("stall %0d block_data", i), bus.md5_block_data,
                        modelBlock("abc", expNonce));
            @(posedge clk); #1;
        end
        bus.md5_block_ready = 1'b1;
        waitResult(1000, "abc");
        checkOutput("abc result_found", bus.result_found, 1'b1);
        checkOutput("abc result_nonce", bus.result_nonce, 32'd105);
        bus.key_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        checkOutput("done ignores key key_ready", bus.key_ready, 1'b0);
        checkOutput("done holds result_valid", bus.result_valid, 1'b1);
        checkOutput("done holds result_nonce", bus.result_nonce, 32'd105);
        checkOutput("done busy low", bus.busy, 1'b0);
        resetDut();

        // Reset with about 30 digests in flight; stale all-zero digests must not register.
        targetNonce = -1;
        nearNonce   = -1;
        lowNonce    = -1;
        applyStimulus("xyz", 3);
        for (int i = 0; i < 200 && pendN.size() < 30; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("in-flight count reached", pendN.size() >= 30, 1'b1);
        resetDut();
        checkOutput("after stale key_ready", bus.key_ready, 1'b1);
        checkOutput("after stale result_valid", bus.result_valid, 1'b0);
        checkOutput("after stale busy", bus.busy, 1'b0);
        checkOutput("after stale block_valid", bus.md5_block_valid, 1'b0);

        // Clean rerun with the same key finds the match at 20.
        targetNonce = 20;
        applyStimulus("xyz", 3);
        waitResult(500, "xyz");
        checkOutput("xyz result_found", bus.result_found, 1'b1);
        checkOutput("xyz result_nonce", bus.result_nonce, 32'd20);
        resetDut();

        // Oversized key_len clamps to 16; three-digit space exhausts after N=999.
        pipeLat     = 5;
        targetNonce = -1;
        nearNonce   = 500;
        exhaustLast = 999;
        applyStimulus("0123456789ABCDEF", 20);
        for (int i = 0; i < 3000 && bus.result_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
            bus.md5_block_ready = (i % 5 != 2);
        end
        checkOutput("exhaust finished", bus.result_valid, 1'b1);
        checkOutput("exhaust blocks issued", issuedBlocks, 999);
        checkOutput("exhaust found low", bus.result_found, 1'b0);
        checkOutput("exhaust nonce zero", bus.result_nonce, 32'd0);
        checkOutput("exhaust drain seen", drainLast >= 0, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
